// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, ALU-slice and response signals of alu_arbiter
interface alu_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 2
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [DATA_W-1:0] alu_acc;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_acc, alu_b, alu_control,
    input  alu_result,
    output resp_valid, resp_id, resp_data,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_acc, alu_b, alu_control,
    output alu_result,
    input  resp_valid, resp_id, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU slice between two requesters
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 2
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   ctrl_q, ctrl_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] alub_q, alub_d;
  logic              rvalid_q, rvalid_d;
  logic              rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              any_valid;
  logic              grant_id;
  logic              ready0, ready1;
  logic [OP_W-1:0]   g_op;
  logic [DATA_W-1:0] g_a, g_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      acc_q    <= '0;
      alub_q   <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      acc_q    <= acc_d;
      alub_q   <= alub_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    acc_d    = acc_q;
    alub_d   = alub_q;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    ready0   = 1'b0;
    ready1   = 1'b0;

    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
    g_op      = grant_id ? bus.req1_op : bus.req0_op;
    g_a       = grant_id ? bus.req1_a  : bus.req0_a;
    g_b       = grant_id ? bus.req1_b  : bus.req0_b;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          ready0  = ~grant_id;
          ready1  = grant_id;
          op_d    = g_op;
          a_d     = g_a;
          b_d     = g_b;
          id_d    = grant_id;
          prio_d  = ~grant_id;
          // Complemented operands are presented during SETUP so every
          // operand bit toggles again in EXEC with the function code settled.
          ctrl_d  = g_op;
          acc_d   = ~g_a;
          alub_d  = ~g_b;
          state_d = SETUP;
        end
      end
      SETUP: begin
        acc_d   = a_q;
        alub_d  = b_q;
        state_d = EXEC;
      end
      EXEC: begin
        rdata_d  = bus.alu_result;
        rid_d    = id_q;
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.alu_acc     = acc_q;
  assign bus.alu_b       = alub_q;
  assign bus.alu_control = ctrl_q;
  assign bus.resp_valid  = rvalid_q;
  assign bus.resp_id     = rid_q;
  assign bus.resp_data   = rdata_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with an event-driven ALU model
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [8:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_arbiter_if #(.DATA_W(8), .OP_W(2)) bus();
  alu_arbiter #(.DATA_W(8), .OP_W(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  // The slice only re-evaluates when an operand changes, like the real one.
  always @(bus.alu_acc or bus.alu_b) begin
    case (bus.alu_control)
      2'b00:   bus.alu_result = bus.alu_acc + bus.alu_b;
      2'b01:   bus.alu_result = ~(bus.alu_acc & bus.alu_b);
      2'b10:   bus.alu_result = {7'b0, bus.alu_acc != bus.alu_b};
      default: bus.alu_result = {7'b0, bus.alu_acc < bus.alu_b};
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", {23'b0, bus.resp_id, bus.resp_data}, 32'h1ff);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("resp_id", bus.resp_id, e[8]);
        chk("resp_data", bus.resp_data, e[7:0]);
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic issue(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input bit drain);
    logic [7:0] na, nb;
    bit got;
    na = ~a;
    nb = ~b;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(id, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.req1_ready : bus.req0_ready;
    end
    chk("grant_seen", got, 1'b1);
    if (!got) begin
      set_req(id, 1'b0, op, a, b);
      return;
    end
    chk("other_ready_low", id ? bus.req0_ready : bus.req1_ready, 1'b0);
    sb.push_back({id, exp});
    @(posedge clk); #1;
    set_req(id, 1'b0, op, a, b);
    @(negedge clk);
    chk("setup_ctrl", bus.alu_control, op);
    chk("setup_acc", bus.alu_acc, na);
    chk("setup_b", bus.alu_b, nb);
    @(negedge clk);
    chk("exec_ctrl", bus.alu_control, op);
    chk("exec_acc", bus.alu_acc, a);
    chk("exec_b", bus.alu_b, b);
    chk("exec_no_resp", bus.resp_valid, 1'b0);
    if (drain) wait_drain("drain");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, bus.req0_ready, 1'b0);
    chk({tag, "_ready1"}, bus.req1_ready, 1'b0);
    chk({tag, "_acc"}, bus.alu_acc, 8'h00);
    chk({tag, "_b"}, bus.alu_b, 8'h00);
    chk({tag, "_ctrl"}, bus.alu_control, 2'b00);
    chk({tag, "_rvalid"}, bus.resp_valid, 1'b0);
    chk({tag, "_rid"}, bus.resp_id, 1'b0);
    chk({tag, "_rdata"}, bus.resp_data, 8'h00);
  endtask

  logic [1:0] c_op0[4] = '{2'b00, 2'b00, 2'b01, 2'b11};
  logic [7:0] c_a0[4]  = '{8'h01, 8'h10, 8'hFF, 8'h01};
  logic [7:0] c_b0[4]  = '{8'h02, 8'h20, 8'hFF, 8'h02};
  logic [7:0] c_e0[4]  = '{8'h03, 8'h30, 8'h00, 8'h01};
  logic [1:0] c_op1[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [7:0] c_a1[4]  = '{8'h80, 8'h05, 8'h0F, 8'h09};
  logic [7:0] c_b1[4]  = '{8'h80, 8'h06, 8'hF0, 8'h03};
  logic [7:0] c_e1[4]  = '{8'h00, 8'h01, 8'hFF, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, ng, last;
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");

    issue(1'b0, 2'b00, 8'h05, 8'h03, 8'h08, 1'b1);
    issue(1'b1, 2'b00, 8'hFF, 8'h02, 8'h01, 1'b1);
    issue(1'b1, 2'b01, 8'hF0, 8'h3C, 8'hCF, 1'b1);
    issue(1'b0, 2'b10, 8'h03, 8'h03, 8'h00, 1'b1);
    issue(1'b0, 2'b11, 8'h03, 8'h03, 8'h00, 1'b1);
    issue(1'b0, 2'b11, 8'h02, 8'h03, 8'h01, 1'b1);

    // contention: both requesters valid continuously
    pulse_reset();
    i0 = 0; i1 = 0; ng = 0; last = 0;
    set_req(1'b0, 1'b1, c_op0[0], c_a0[0], c_b0[0]);
    set_req(1'b1, 1'b1, c_op1[0], c_a1[0], c_b1[0]);
    for (int k = 0; k < 100 && (i0 < 4 || i1 < 4); k++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        chk("cont_one_hot", bus.req0_ready & bus.req1_ready, 1'b0);
        chk("cont_grant", bus.req1_ready, ng % 2);
        if (ng > 0) chk("cont_spacing", cyc - last, 4);
        last = cyc;
        ng++;
        if (bus.req1_ready) begin
          sb.push_back({1'b1, c_e1[i1]}); i1++;
        end else begin
          sb.push_back({1'b0, c_e0[i0]}); i0++;
        end
        @(posedge clk); #1;
        if (i0 < 4) set_req(1'b0, 1'b1, c_op0[i0], c_a0[i0], c_b0[i0]);
        else        set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
        if (i1 < 4) set_req(1'b1, 1'b1, c_op1[i1], c_a1[i1], c_b1[i1]);
        else        set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
      end
    end
    chk("cont_grants", ng, 8);
    wait_drain("cont_drain");

    // back-pressure
    bus.resp_ready = 1'b0;
    issue(1'b0, 2'b00, 8'h11, 8'h22, 8'h33, 1'b0);
    set_req(1'b1, 1'b1, 2'b00, 8'h01, 8'h01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", bus.resp_valid, 1'b1);
      chk("bp_data", bus.resp_data, 8'h33);
      chk("bp_id", bus.resp_id, 1'b0);
      chk("bp_ready0", bus.req0_ready, 1'b0);
      chk("bp_ready1", bus.req1_ready, 1'b0);
    end
    @(posedge clk); #1 bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", bus.req1_ready, 1'b1);
    if (bus.req1_ready) sb.push_back({1'b1, 8'h02});
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_drain("bp_drain");

    // reset while in EXEC drops the command and restores prio
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 2'b00, 8'h04, 8'h04);
    @(negedge clk);
    chk("rx_accept", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rx");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rx_no_resp", bus.resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 2'b00, 8'h07, 8'h08);
    set_req(1'b1, 1'b1, 2'b01, 8'hAA, 8'h55);
    @(negedge clk);
    chk("rx_prio_r0", bus.req0_ready, 1'b1);
    chk("rx_prio_r1", bus.req1_ready, 1'b0);
    if (bus.req0_ready) sb.push_back({1'b0, 8'h0F});
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    wait_drain("rx_drain");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin controller that shares the single 8-bit ALU slice between independent command sources, such as the instruction sequencer and a debug or DMA port. It accepts one operation at a time over valid/ready, drives the ALU's accumulator operand, second operand and 2-bit function code in a fixed sequence, registers the result, and returns it on a valid/ready response channel tagged with the requester ID.

## Interface

Parameters:
- DATA_W, 8, operand and result width; must match the ALU slice.
- OP_W, 2, ALU function-code width: 00 add, 01 nand, 10 not-equal flag, 11 unsigned less-than flag.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  OP_W  requester 0 function code.
- req0_a  in  DATA_W  requester 0 accumulator operand.
- req0_b  in  DATA_W  requester 0 second operand.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  as above, for requester 1.
- alu_acc  out  DATA_W  to ALU accumulator input; registered.
- alu_b  out  DATA_W  to ALU second input; registered.
- alu_control  out  OP_W  to ALU function select; registered.
- alu_result  in  DATA_W  ALU output (combinational).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_id  out  1  requester that issued the command.
- resp_data  out  DATA_W  registered ALU result.

## Operation

- States: IDLE, SETUP, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid is high, grant one requester.
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester.
  - On the accepting edge, capture op, a, b and id into internal registers, then go to SETUP.
- Round-robin arbitration:
  - prio register resets to 0.
  - If both requesters are valid, grant prio.
  - If only one is valid, grant it.
  - After any grant, prio becomes the non-granted ID.
  - No requester waits more than one other transaction.
- SETUP:
  - alu_control is loaded with the captured op.
  - alu_acc and alu_b are loaded with the bitwise complement of the captured a and b.
  - Purpose: the ALU slice re-evaluates only on operand events, so every bit of both operands must change in EXEC with the new function code already stable.
- EXEC:
  - alu_acc and alu_b are loaded with the true captured operands.
  - alu_control is held.
  - At the end of the cycle, resp_data is loaded from alu_result and resp_id from the captured id; go to RESP.
- RESP:
  - resp_valid is high.
  - When resp_ready is high on an edge, clear resp_valid and return to IDLE.
  - resp_data and resp_id are stable while resp_valid is high.
- Result rules:
  - add wraps modulo 2^DATA_W; no carry is reported.
  - Codes 10 and 11 return 8'h01 or 8'h00.
  - The arbiter passes alu_result through unmodified.
- No new command is accepted outside IDLE; requesters hold valid and their fields stable until ready.

## Timing

- Reset values: state IDLE, prio 0, req0_ready/req1_ready 0, alu_acc 0, alu_b 0, alu_control 0, resp_valid 0, resp_id 0, resp_data 0.
- Accept on edge N:
  - SETUP during cycle N+1.
  - EXEC during cycle N+2.
  - resp_valid high from cycle N+3.
- Minimum occupancy is 4 cycles per command (IDLE, SETUP, EXEC, RESP with resp_ready already high). Peak throughput is one command per 4 cycles.
- Back-pressure: RESP holds indefinitely while resp_ready is low. Requesters see ready low throughout.
- Reset asserted in any state returns to IDLE on that edge. The in-flight command is dropped with no response, and prio returns to 0.
- A request whose valid drops before grant is not tracked; no error is raised.

## Test plan

- Single add, idle bus: req0 op 00, a 8'h05, b 8'h03 → req0_ready pulses once; alu_control 00 in SETUP; alu_acc/alu_b 8'hFA/8'hFC in SETUP, then 8'h05/8'h03 in EXEC; resp_valid 3 cycles after accept with resp_id 0, resp_data 8'h08.
- Wrap and nand: req1 add 8'hFF+8'h02 → resp_data 8'h01, resp_id 1. Then req1 nand 8'hF0,8'h3C → resp_data 8'hCF.
- Contention: both valid continuously, 4 commands each, resp_ready tied high → grants alternate 0,1,0,1,…; responses arrive in grant order every 4 cycles.
- Identical operands, changing op: req0 op 10 with a=b=8'h03 → 8'h00. Then req0 op 11 with 3,3 → 8'h00. Then op 11 with 2,3 → 8'h01. The flags must be correct despite repeated operands.
- Back-pressure: resp_ready low for 5 cycles in RESP → resp_valid, resp_data and resp_id held; req0_ready and req1_ready stay 0; after release, the next grant occurs on the following IDLE cycle.
- Reset in EXEC: assert reset for 1 cycle mid-command → all outputs return to reset values the next cycle and no response is emitted; a subsequent command completes normally with prio 0.
